// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI4-Lite memory slave: response codes and read FSM states.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCESS = 2'd1,
    R_RESP   = 2'd2
  } rd_state_t;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  function automatic resp_t resp_of(input logic ok);
    return ok ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-organised 1R1W storage with byte-lane write enables and a registered read port.
module axi_mem_array
  import axi_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wbe,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Non-blocking read of the same word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int b = 0; b < STRB_W; b++) begin
      if (we && wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4-Lite memory slave: independent AW/W holding registers feeding a single
// write commit, and a three-state read FSM sharing one 1R1W word array.
module axi_slave_mem
  import axi_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so BASE_ADDR + size cannot wrap at the top of the address map.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // ---------------- write path ----------------
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [3:0]            w_strb_q;
  logic                  commit, wr_ok;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign commit  = aw_held && w_held && !bvalid;
  assign wr_ok   = addr_ok(aw_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= resp_of(wr_ok);
    end else begin
      if (awvalid && awready) aw_held <= 1'b1;
      if (wvalid && wready)   w_held  <= 1'b1;
      if (bvalid && bready)   bvalid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (awvalid && awready) aw_q <= awaddr;
    if (wvalid && wready) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // ---------------- read path ----------------
  rd_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] ar_q;
  logic                  rd_ok, rd_ok_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign rd_ok = addr_ok(ar_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= R_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) state_nxt = R_ACCESS;
      end
      R_ACCESS: state_nxt = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arvalid && arready) ar_q <= araddr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ok_q <= 1'b0;
      rresp   <= OKAY;
    end else if (state == R_ACCESS) begin
      rd_ok_q <= rd_ok;
      rresp   <= resp_of(rd_ok);
    end
  end

  // Error reads return zero; the array output only changes in R_ACCESS so this is stable in R_RESP.
  assign rdata = (rvalid && rd_ok_q) ? mem_rdata : '0;

  axi_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (commit && wr_ok),
    .waddr(addr_idx(aw_q)),
    .wbe  (w_strb_q),
    .wdata(w_data_q),
    .re   ((state == R_ACCESS) && rd_ok),
    .raddr(addr_idx(ar_q)),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench: directed vector table, hand-built timing corners and
// a randomized phase checked against a word-array model of the memory map.
module tb_axi_slave_mem;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_ERR = 2'b10;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0, n_err = 0;

  axi_slave_mem dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_awready"}, 32'(awready), 1);
    chk({tag, "_wready"},  32'(wready),  1);
    chk({tag, "_bvalid"},  32'(bvalid),  0);
    chk({tag, "_bresp"},   32'(bresp),   0);
    chk({tag, "_arready"}, 32'(arready), 1);
    chk({tag, "_rvalid"},  32'(rvalid),  0);
    chk({tag, "_rresp"},   32'(rresp),   0);
    chk({tag, "_rdata"},   rdata,        0);
  endtask

  // All drivers run from negedges; a ready seen at a negedge means a handshake at the next posedge.
  task automatic send_aw(input logic [31:0] a, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    awaddr = a; awvalid = 1;
    while (!awready && t < 60) begin @(negedge clk); t++; end
    if (!awready) chk("aw_timeout", 32'(awready), 1);
    @(negedge clk); awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1;
    while (!wready && t < 60) begin @(negedge clk); t++; end
    if (!wready) chk("w_timeout", 32'(wready), 1);
    @(negedge clk); wvalid = 0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int t = 0;
    bready = 1;
    while (!bvalid && t < 60) begin @(negedge clk); t++; end
    if (!bvalid) chk("b_timeout", 32'(bvalid), 1);
    resp = bresp;
    @(negedge clk); bready = 0;
    chk("bvalid_drop", 32'(bvalid), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    wait_b(resp);
  endtask

  // Handshake cycle c; rvalid must appear in cycle c+2.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t = 0, lat = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (!arready && t < 60) begin @(negedge clk); t++; end
    if (!arready) chk("ar_timeout", 32'(arready), 1);
    do begin
      @(negedge clk); lat++; arvalid = 0;
    end while (!rvalid && lat < 20);
    chk("r_latency", 32'(lat), 2);
    d = rdata; resp = rresp;
    @(negedge clk); rready = 0;
    chk("rvalid_drop", 32'(rvalid), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] model[16];
  logic [31:0] rd, a, d;
  logic [1:0]  rs;

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, R_OK,  32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, R_OK,  32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, R_OK,  32'h11BB_33DD};
    tbl[3]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, R_ERR, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0002, 32'h0,         4'h0, R_ERR, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, R_OK,  32'hA5A5_0000};
    tbl[6]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, R_OK,  32'h0};
    tbl[7]  = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, R_OK,  32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, R_OK,  32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 32'h0000_0021, 32'h0,         4'hF, R_ERR, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, R_OK,  32'h11BB_33DD};
    tbl[11] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, R_OK,  32'h0};
    tbl[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, R_OK,  32'h0BAD_C0DE};
    tbl[13] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, R_ERR, 32'h0};
    tbl[14] = '{1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 4'hF, R_ERR, 32'h0};
    tbl[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, R_ERR, 32'h0};

    repeat (3) @(negedge clk);
    chk_rst("rst_hold");
    reset = 0;
    @(negedge clk);
    chk_rst("rst_rel");

    // AW at cycle 0, W three cycles later.
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 3, rs);
    chk("w10_resp", 32'(rs), R_OK);
    do_read(32'h10, rd, rs);
    chk("r10_resp", 32'(rs), R_OK);
    chk("r10_data", rd, 32'hDEAD_BEEF);

    do_write(32'h0, 32'hA5A5_0000, 4'hF, 1, 0, rs);
    chk("w0_resp", 32'(rs), R_OK);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 3, rs);
        chk($sformatf("tbl%0d_bresp", i), 32'(rs), 32'(tbl[i].resp));
      end else begin
        do_read(tbl[i].addr, rd, rs);
        chk($sformatf("tbl%0d_rresp", i), 32'(rs), 32'(tbl[i].resp));
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      end
    end

    // Random phase over a 16-word window at 0x100 plus misaligned and out-of-range hits.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_write(32'h100 + 32'(4 * i), model[i], 4'hF, 0, 0, rs);
      chk("pre_bresp", 32'(rs), R_OK);
    end
    for (int k = 0; k < 60; k++) begin
      int sel, idx;
      logic ok;
      logic [3:0] s;
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      if (sel < 8)       a = 32'h100 + 32'(4 * idx);
      else if (sel == 8) a = 32'h100 + 32'(4 * idx) + 32'($urandom_range(1, 3));
      else               a = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      ok = (a < 32'h1000) && (a[1:0] == 2'b00);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), rs);
        chk($sformatf("rnd%0d_bresp", k), 32'(rs), ok ? R_OK : R_ERR);
        if (ok)
          for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        do_read(a, rd, rs);
        chk($sformatf("rnd%0d_rresp", k), 32'(rs), ok ? R_OK : R_ERR);
        chk($sformatf("rnd%0d_rdata", k), rd, ok ? model[idx] : 32'h0);
      end
    end

    // Commit and R_ACCESS hit word 0 in the same cycle: read sees the old value.
    do_write(32'h0, 32'h1, 4'hF, 0, 0, rs);
    awaddr = 0; awvalid = 1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1;
    araddr = 0; arvalid = 1; rready = 1; bready = 0;
    chk("coll_ready", {29'h0, awready, wready, arready}, 32'h7);
    @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("coll_rvalid", 32'(rvalid), 1);
    chk("coll_rdata", rdata, 32'h1);
    chk("coll_bvalid", 32'(bvalid), 1);
    @(negedge clk); rready = 0; bready = 1;
    @(negedge clk); bready = 0;
    do_read(32'h0, rd, rs);
    chk("coll_after", rd, 32'h2);

    // Response back-pressure: a second pair waits in the holding registers.
    fork
      send_aw(32'h40, 0);
      send_w(32'h5566_7788, 4'hF, 0);
    join
    @(negedge clk);
    chk("bp_b1_valid", 32'(bvalid), 1);
    awaddr = 32'h44; awvalid = 1; wdata = 32'h99AA_BBCC; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); awvalid = 0; wvalid = 0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_awready", 32'(awready), 0);
      chk("bp_wready",  32'(wready),  0);
      chk("bp_bvalid",  32'(bvalid),  1);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk); bready = 0;
    chk("bp_gap", 32'(bvalid), 0);
    @(negedge clk);
    chk("bp_b2_valid", 32'(bvalid), 1);
    chk("bp_held_clear", {30'h0, awready, wready}, 32'h3);
    bready = 1;
    @(negedge clk); bready = 0;
    do_read(32'h40, rd, rs);
    chk("bp_r40", rd, 32'h5566_7788);
    do_read(32'h44, rd, rs);
    chk("bp_r44", rd, 32'h99AA_BBCC);

    // Reset with rvalid high and an address held.
    araddr = 32'h44; arvalid = 1; rready = 0; awaddr = 32'h44; awvalid = 1;
    @(negedge clk); arvalid = 0; awvalid = 0;
    @(negedge clk);
    chk("mid_rvalid", 32'(rvalid), 1);
    chk("mid_awready", 32'(awready), 0);
    #2 reset = 1;
    #1 chk_rst("mid_rst");
    @(negedge clk); reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 0);
      chk("post_rst_bvalid", 32'(bvalid), 0);
    end
    do_read(32'h44, rd, rs);
    chk("post_rst_data", rd, 32'h99AA_BBCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
